// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul stream controller.
// Holds the FSM state encoding plus the default matrix geometry.
package matmul_pkg;

  localparam int DEF_N          = 8;
  localparam int DEF_LOG2_N     = 3;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAT_SIZE       = DEF_N * DEF_N;

  // START cycle plus the first WAIT cycle may still see done from the previous run.
  localparam logic [31:0] BLANK_CYCLES = 32'd2;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    C_ADDR,
    C_DATA,
    C_OUT
  } state_t;

endpackage

// File: rtl/matmul_stream_ctrl.sv
// Stream host for the matmul engine: loads A and B from a valid/ready stream, runs the
// engine, measures start-to-done latency and streams C back out with backpressure.
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int LOG2_N     = DEF_LOG2_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2 * LOG2_N
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           cycle_count,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic                  a_wr_en,
  output logic [ADDR_WIDTH-1:0] a_wr_addr,
  output logic [DATA_WIDTH-1:0] a_din,
  output logic                  b_wr_en,
  output logic [ADDR_WIDTH-1:0] b_wr_addr,
  output logic [DATA_WIDTH-1:0] b_din,
  output logic [ADDR_WIDTH-1:0] c_rd_addr,
  input  logic [DATA_WIDTH-1:0] c_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N * N - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           cnt;
  logic [31:0]           cnt_inc;
  logic                  fire;
  logic                  last_beat;

  // in_ready is itself a register, so the handshake depends only on flops and the input.
  assign fire      = in_valid && in_ready;
  assign last_beat = (idx == LAST_IDX);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 32'd1;
  assign c_rd_addr = c_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= LOAD_A;
      idx         <= '0;
      c_idx       <= '0;
      cnt         <= '0;
      cycle_count <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      mm_start    <= 1'b0;
      a_wr_en     <= 1'b0;
      a_wr_addr   <= '0;
      a_din       <= '0;
      b_wr_en     <= 1'b0;
      b_wr_addr   <= '0;
      b_din       <= '0;
    end else begin
      // NOTE: non-blocking defaults at the top turn the strobes into one-cycle pulses
      // while every branch below still reads the pre-edge register values.
      a_wr_en  <= 1'b0;
      b_wr_en  <= 1'b0;
      mm_start <= 1'b0;

      case (state)
        LOAD_A, LOAD_B: begin
          busy <= (state == LOAD_B) || (idx != '0) || fire;
          if (fire) begin
            if (state == LOAD_A) begin
              a_wr_en   <= 1'b1;
              a_wr_addr <= idx;
              a_din     <= in_data;
            end else begin
              b_wr_en   <= 1'b1;
              b_wr_addr <= idx;
              b_din     <= in_data;
            end
            idx <= last_beat ? '0 : idx + 1'b1;
            if (last_beat) begin
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state    <= START;
                in_ready <= 1'b0;
                mm_start <= 1'b1;
                cnt      <= '0;
              end
            end
          end
        end

        START: begin
          cnt   <= cnt_inc;
          state <= WAIT;
        end

        WAIT: begin
          cnt <= cnt_inc;
          if (mm_done && (cnt >= BLANK_CYCLES)) begin
            cycle_count <= cnt;
            c_idx       <= '0;
            state       <= C_ADDR;
          end
        end

        C_ADDR: state <= C_DATA;

        C_DATA: begin
          out_data  <= c_dout;
          out_valid <= 1'b1;
          out_last  <= (c_idx == LAST_IDX);
          state     <= C_OUT;
        end

        C_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state    <= LOAD_A;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              c_idx    <= '0;
            end else begin
              c_idx <= c_idx + 1'b1;
              state <= C_ADDR;
            end
          end
        end

        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
